// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit scheduler.
package i2s_pkg;

  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;

  typedef struct packed {
    logic [I2S_DATA_W-1:0] left;
    logic [I2S_DATA_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic {IDLE, RUN} sched_state_t;

endpackage

// File: rtl/i2s_tx_scheduler_if.sv
// Stereo sample stream from the effects chain into the TX scheduler.
interface i2s_tx_scheduler_if #(
  parameter int DATA_W = i2s_pkg::I2S_DATA_W
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_frame_counter.sv
// Frame timing: IDLE/RUN state, slot counter, lrclk and the boundary/mid strobes.
module i2s_frame_counter
  import i2s_pkg::*;
#(
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic sclk,
  input  logic rst,
  input  logic enable,
  output logic lrclk,
  output logic frame_start,
  output logic boundary,
  output logic mid
);
  localparam int CNT_W = $clog2(2*SLOT_W);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SLOT_W-1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*SLOT_W-1);

  sched_state_t     state;
  logic [CNT_W-1:0] cnt;

  // A boundary is either the last cycle of a frame or the IDLE->RUN launch.
  assign boundary = (state == IDLE) ? enable : (cnt == CNT_LAST);
  assign mid      = (state == RUN) && (cnt == CNT_MID);

  // Frame FSM; enable only matters on boundaries so a frame always completes.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lrclk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (boundary) begin
        cnt         <= '0;
        lrclk       <= 1'b0;
        state       <= enable ? RUN : IDLE;
        frame_start <= enable;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (mid) lrclk <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_scheduler.sv
// I2S TX frame scheduler: one-deep pair buffer, active pair, underrun policy, tx_data mux.
module i2s_tx_scheduler
  import i2s_pkg::*;
#(
  parameter int DATA_W        = I2S_DATA_W,
  parameter int SLOT_W        = I2S_SLOT_W,
  parameter int UNDERRUN_MODE = 0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              enable,
  i2s_tx_scheduler_if.slave s,
  output logic              lrclk,
  output logic [DATA_W-1:0] tx_data,
  output logic              frame_start,
  output logic              underrun,
  output logic [15:0]       underrun_count
);
  stereo_sample_t pend;
  stereo_sample_t active;
  logic           pend_v;
  logic           boundary;
  logic           mid;
  logic           accept;

  i2s_frame_counter #(.SLOT_W(SLOT_W)) u_frame_counter (
    .sclk        (sclk),
    .rst         (rst),
    .enable      (enable),
    .lrclk       (lrclk),
    .frame_start (frame_start),
    .boundary    (boundary),
    .mid         (mid)
  );

  // Pend is the only entry point; ready stays low until a boundary drains it.
  assign s.s_ready = !pend_v && !rst;
  assign accept    = s.s_valid && s.s_ready;

  // Buffer fill/drain, underrun handling and the per-slot word select.
  always_ff @(posedge sclk) begin
    if (rst) begin
      pend           <= '0;
      pend_v         <= 1'b0;
      active         <= '0;
      tx_data        <= '0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun <= 1'b0;
      // Accept only happens with pend empty, so it never collides with a drain.
      if (accept) begin
        pend   <= '{left: s.s_left, right: s.s_right};
        pend_v <= 1'b1;
      end
      if (boundary) begin
        if (!enable) begin
          tx_data <= '0;
        end else if (pend_v) begin
          active  <= pend;
          pend_v  <= 1'b0;
          tx_data <= pend.left;
        end else begin
          // A pair landing on this same edge is too late for this frame.
          underrun <= 1'b1;
          if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
          if (UNDERRUN_MODE == 0) begin
            active  <= '0;
            tx_data <= '0;
          end else begin
            tx_data <= active.left;
          end
        end
      end else if (mid) begin
        tx_data <= active.right;
      end
    end
  end

endmodule
